// File: rtl/capture_dump.sv
// rtl/capture_dump.sv - reads the capture RAM oldest-first and streams each byte to a transmitter
// Optional feature macro: DUMP_CHKSUM_EN appends an 8-bit sum trailer byte after the samples.
module capture_dump #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump_req,
  input  logic            capture_done,
  input  logic [LOG2-1:0] wr_ptr,
  input  logic [7:0]      rdata,
  input  logic            tx_done,
  output logic            re,
  output logic [LOG2-1:0] raddr,
  output logic [7:0]      tx_data,
  output logic            trmt,
  output logic            clr_cap_done,
  output logic            dumping
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    LATCH   = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Last valid RAM index, sized to the full pointer width so the compare is exact.
  localparam logic [LOG2-1:0] LAST    = LOG2'(ENTRIES - 1);
  localparam logic [LOG2-1:0] PTR_ONE = LOG2'(1);

  state_t          state;
  state_t          state_nx;
  logic [LOG2-1:0] rd_ptr;
  logic [LOG2-1:0] byte_cnt;
  logic [7:0]      tx_data_q;
  logic            start;
  logic            last_byte;

`ifdef DUMP_CHKSUM_EN
  logic [7:0]      chk;
  logic            chk_phase;
`endif

  assign start     = dump_req && capture_done;
  assign last_byte = (byte_cnt == LAST);
  assign tx_data   = tx_data_q;

  // State register; reset drops straight back to IDLE even mid-dump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and strobes; all strobes are pure functions of the state.
  always_comb begin
    state_nx     = state;
    re           = 1'b0;
    raddr        = '0;
    trmt         = 1'b0;
    clr_cap_done = 1'b0;
    dumping      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nx = RD;
      end
      RD: begin
        re       = 1'b1;
        raddr    = rd_ptr;
        state_nx = LATCH;
      end
      LATCH: begin
        state_nx = SEND;
      end
      SEND: begin
        trmt     = 1'b1;
        state_nx = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done) begin
`ifdef DUMP_CHKSUM_EN
          // The trailer needs no RAM read, so it goes straight to LATCH.
          if (chk_phase)      state_nx = DONE;
          else if (last_byte) state_nx = LATCH;
          else                state_nx = RD;
`else
          if (last_byte) state_nx = DONE;
          else           state_nx = RD;
`endif
        end
      end
      DONE: begin
        clr_cap_done = 1'b1;
        state_nx     = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Read pointer and byte counter; the pointer wraps at ENTRIES, not at 2^LOG2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      byte_cnt <= '0;
    end else begin
      if (state == IDLE && start) begin
        rd_ptr   <= wr_ptr;
        byte_cnt <= '0;
      end else if (state == WAIT_TX && tx_done && !last_byte) begin
        byte_cnt <= byte_cnt + PTR_ONE;
        rd_ptr   <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_ONE;
      end
    end
  end

`ifdef DUMP_CHKSUM_EN
  // Transmit byte register; in the trailer phase it carries the running sum instead of RAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q <= '0;
    end else if (state == LATCH) begin
      tx_data_q <= chk_phase ? chk : rdata;
    end
  end

  // Running 8-bit sum of the sample bytes and the trailer-phase flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk       <= '0;
      chk_phase <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        chk       <= '0;
        chk_phase <= 1'b0;
      end else if (state == LATCH && !chk_phase) begin
        chk <= chk + rdata;
      end else if (state == WAIT_TX && tx_done && last_byte) begin
        chk_phase <= 1'b1;
      end
    end
  end
`else
  // Transmit byte register; only ever loaded from RAM data while in LATCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q <= '0;
    end else if (state == LATCH) begin
      tx_data_q <= rdata;
    end
  end
`endif

endmodule

// File: tb/tb_capture_dump.sv
// tb/tb_capture_dump.sv - randomized-response bench for capture_dump with a queue-based reference model
module tb_capture_dump;

  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;
`ifdef DUMP_CHKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int EXP_TRMT = ENTRIES + EXTRA;

  logic            clk;
  logic            rst_n;
  logic            dump_req;
  logic            capture_done;
  logic [LOG2-1:0] wr_ptr;
  logic [7:0]      rdata;
  logic            tx_done;
  logic            re;
  logic [LOG2-1:0] raddr;
  logic [7:0]      tx_data;
  logic            trmt;
  logic            clr_cap_done;
  logic            dumping;

  capture_dump #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dump_req     (dump_req),
    .capture_done (capture_done),
    .wr_ptr       (wr_ptr),
    .rdata        (rdata),
    .tx_done      (tx_done),
    .re           (re),
    .raddr        (raddr),
    .tx_data      (tx_data),
    .trmt         (trmt),
    .clr_cap_done (clr_cap_done),
    .dumping      (dumping)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int trmt_cnt = 0;
  int clr_cnt = 0;
  int byte_idx = 0;
  int tx_cnt = 0;
  int last_done_cyc = 0;
  bit noise_en = 0;
  logic [7:0] held;
  logic [7:0] ram [0:511];
  int exp_addr[$];
  logic [7:0] exp_byte[$];

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM model: data appears the cycle after re.
  always @(posedge clk) if (re) rdata <= ram[raddr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event with no expectation outstanding (cycle %0d)", name, cyc);
  endtask

  // Reference model: the exact address and byte streams a dump starting at wp must produce.
  task automatic build(input int wp);
    logic [7:0] sum;
    exp_addr.delete();
    exp_byte.delete();
    byte_idx = 0;
    sum = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      int a;
      a = (wp + i) % ENTRIES;
      exp_addr.push_back(a);
      exp_byte.push_back(ram[a]);
      sum = sum + ram[a];
    end
`ifdef DUMP_CHKSUM_EN
    exp_byte.push_back(sum);
`endif
  endtask

  // Transmitter model: tx_done 10 cycles after each trmt, optional spurious pulses in SEND/RD.
  initial begin
    tx_done = 0;
    forever begin
      @(negedge clk);
      tx_done = 0;
      if (!rst_n) begin
        tx_cnt = 0;
      end else begin
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) begin
            tx_done = 1;
            last_done_cyc = cyc;
            check("tx_hold", tx_data, held);
          end
        end
        if (trmt) begin
          held = tx_data;
          tx_cnt = 10;
          if (noise_en && $urandom_range(0, 1) == 1) tx_done = 1;
        end else if (re && noise_en && $urandom_range(0, 2) == 0) begin
          tx_done = 1;
        end
      end
    end
  end

  // Compare process: every read address and every transmitted byte against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", {re, trmt, clr_cap_done, dumping, raddr, tx_data}, 0);
    end else begin
      if (re) begin
        check("raddr_below_entries", raddr < ENTRIES, 1);
        if (exp_addr.size() == 0) flag_fail("unexpected_re");
        else check("raddr", raddr, exp_addr.pop_front());
      end
      if (trmt) begin
        trmt_cnt++;
        if (exp_byte.size() == 0) begin
          flag_fail("unexpected_trmt");
        end else begin
          check("tx_data", tx_data, exp_byte.pop_front());
          if (byte_idx > 0) check("trmt_gap", cyc - last_done_cyc, (byte_idx < ENTRIES) ? 3 : 2);
          byte_idx++;
        end
      end
      if (clr_cap_done) begin
        clr_cnt++;
        check("clr_after_all_bytes", exp_byte.size() + exp_addr.size(), 0);
      end
    end
  end

  task automatic start_dump(input int wp);
    wr_ptr = LOG2'(wp);
    capture_done = 1;
    trmt_cnt = 0;
    clr_cnt = 0;
    @(posedge clk); #1 dump_req = 1;
    @(posedge clk); #1 dump_req = 0;
    check("lat_re", re, 1);
    check("lat_raddr", raddr, wp);
    check("lat_dumping", dumping, 1);
    @(posedge clk); #1 check("lat_n2_trmt", trmt, 0);
    @(posedge clk); #1 check("lat_n3_trmt", trmt, 1);
  endtask

  task automatic run_dump(input int wp, input bit mid);
    int n;
    start_dump(wp);
    if (mid) begin
      repeat (300) @(posedge clk);
      #1 dump_req = 1;
      capture_done = 0;
      @(posedge clk); #1 dump_req = 0;
    end
    n = 0;
    while (clr_cnt == 0 && n < 8000) begin
      @(posedge clk);
      n++;
    end
    if (clr_cnt == 0) flag_fail("dump_timeout");
    #1 check("dumping_end", dumping, 0);
    repeat (5) @(posedge clk);
    #1 check("clr_once", clr_cnt, 1);
    check("trmt_total", trmt_cnt, EXP_TRMT);
    check("model_drained", exp_byte.size() + exp_addr.size(), 0);
    capture_done = 0;
  endtask

  initial begin
    int n;
    rst_n = 0;
    dump_req = 0;
    capture_done = 0;
    wr_ptr = 0;
    for (int i = 0; i < 512; i++) ram[i] = i[7:0];
    repeat (3) @(posedge clk);
    #1 check("reset_state", {re, trmt, clr_cap_done, dumping, raddr, tx_data}, 0);
    rst_n = 1;
    repeat (3) @(posedge clk);

    // Straight dump from address 0.
    build(0);
    check("pin_t1_first", exp_byte[0], 8'h00);
    check("pin_t1_255", exp_byte[255], 8'hFF);
    check("pin_t1_256", exp_byte[256], 8'h00);
    check("pin_t1_383", exp_byte[383], 8'h7F);
    run_dump(0, 0);

    // Wrapped dump with spurious tx_done, repeated dump_req and capture_done falling.
    build(100);
    check("pin_t2_first", exp_byte[0], 8'h64);
    check("pin_t2_addr283", exp_addr[283], 383);
    check("pin_t2_addr284", exp_addr[284], 0);
    check("pin_t2_byte284", exp_byte[284], 8'h00);
    noise_en = 1;
    run_dump(100, 1);
    noise_en = 0;

    // dump_req without a completed capture is ignored.
    capture_done = 0;
    @(posedge clk); #1 dump_req = 1;
    @(posedge clk); #1 dump_req = 0;
    for (int i = 0; i < 50; i++) begin
      check("idle_quiet", {re, trmt, dumping}, 0);
      @(posedge clk); #1;
    end

    // Reset after the 5th trmt, then a fresh dump from the same wr_ptr.
    build(200);
    start_dump(200);
    n = 0;
    while (trmt_cnt < 5 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (trmt_cnt < 5) flag_fail("reset_test_timeout");
    #3 rst_n = 0;
    exp_addr.delete();
    exp_byte.delete();
    repeat (4) @(posedge clk);
    #1 rst_n = 1;
    repeat (30) @(posedge clk);
    build(200);
    run_dump(200, 0);

`ifdef DUMP_CHKSUM_EN
    // Checksum trailer over an all-ones buffer.
    for (int i = 0; i < 512; i++) ram[i] = 8'h01;
    build(0);
    check("pin_chk_size", exp_byte.size(), 385);
    check("pin_chk_last", exp_byte[384], 8'h80);
    run_dump(0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
